// File: rtl/conv3x3_window_ctrl.sv
// Sequencer for a 3x3 stride-1 window generator (shift register + two line
// buffers). Consumes a raster pixel stream, drives the generator shift enable,
// qualifies only windows fully inside the image and freezes the generator
// while the convolution engine applies backpressure.
//
// state | meaning
// IDLE  | waiting for start, stream not accepted
// RUN   | accepting pixels, tracking row/col, qualifying windows
// DRAIN | last pixel shifted, waiting for the final window to be taken
// DONE  | one-cycle frame_done pulse, then back to IDLE
module conv3x3_window_ctrl #(
  parameter int IMG_WIDHT  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             shift_en,
  input  logic             w_ready,
  output logic             window_valid,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST_COL = CNT_W'(IMG_WIDHT - 1);
  localparam logic [CNT_W-1:0] LP_LAST_ROW = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] LP_TWO      = CNT_W'(2);

  state_t           r_state;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_win_row;
  logic [CNT_W-1:0] r_win_col;
  logic             r_win_valid;
  logic             r_frame_done;

  logic w_s_ready;
  logic w_shift;
  logic w_accept;
  logic w_qualify;

  // Handshake and window qualification for the pixel currently offered.
  // A pending window that is not taken freezes the stream, which keeps the
  // generator contents and the registered coordinates stable.
  always_comb begin
    w_s_ready = (r_state == ST_RUN) && (!r_win_valid || w_ready);
    w_shift   = s_valid && w_s_ready;
    w_accept  = r_win_valid && w_ready;
    w_qualify = (r_row >= LP_TWO) && (r_col >= LP_TWO);
  end

  // Frame FSM, row/col tracking and registered window outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (abort) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_RUN: begin
          if (w_shift) begin
            // The new pixel decides validity even if the old window was taken.
            r_win_valid <= w_qualify;
            if (w_qualify) begin
              r_win_row <= r_row - LP_TWO;
              r_win_col <= r_col - LP_TWO;
            end
            if (r_col == LP_LAST_COL) begin
              r_col <= '0;
              if (r_row == LP_LAST_ROW) begin
                r_state <= ST_DRAIN;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else if (w_accept) begin
            r_win_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!r_win_valid || w_accept) begin
            r_win_valid  <= 1'b0;
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready      = w_s_ready;
  assign shift_en     = w_shift;
  assign window_valid = r_win_valid;
  assign win_row      = r_win_row;
  assign win_col      = r_win_col;
  assign frame_done   = r_frame_done;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// Bench for conv3x3_window_ctrl on an 8x6 image. Stimulus and checking are
// decoupled: a monitor turns every observed pixel handshake into the expected
// window (pushed to a queue) and pops/compares on every accepted window.
module tb_conv3x3_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          s_valid;
  logic          s_ready;
  logic          shift_en;
  logic          w_ready;
  logic          window_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;
  logic          busy;

  conv3x3_window_ctrl #(
    .IMG_WIDHT (W),
    .IMG_HEIGHT(H),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .shift_en    (shift_en),
    .w_ready     (w_ready),
    .window_valid(window_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r;
    int c;
  } win_t;

  win_t q[$];
  int   total = 0;
  int   bad = 0;
  int   pix = 0;
  int   win_count = 0;
  int   frame_count = 0;
  int   cyc = 0;
  int   first_shift_cyc = 0;
  int   last_shift_cyc = 0;
  bit   exp_wv = 1'b0;
  bit   mon_en = 1'b0;
  bit   chk_lat = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    q.delete();
    pix = 0;
    win_count = 0;
    exp_wv = 1'b0;
  endtask

  // Monitor: samples mid low-phase, after the driver has updated inputs.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        win_t e;
        cyc++;
        chk("window_valid", window_valid, exp_wv);
        chk("shift_en", shift_en, s_valid & s_ready);
        chk("fd_wv_excl", frame_done & window_valid, 0);
        if (window_valid && !w_ready) chk("bp_s_ready", s_ready, 0);
        if (window_valid && w_ready && !abort) begin
          if (q.size() == 0) begin
            chk("win_unexpected", 0, 1);
          end else begin
            e = q.pop_front();
            chk("win_row", win_row, e.r);
            chk("win_col", win_col, e.c);
            win_count++;
          end
        end
        if (frame_done) begin
          frame_count++;
          if (chk_lat) chk("fd_latency", cyc - last_shift_cyc, 2);
        end
        if (abort) begin
          exp_wv = 1'b0;
          q.delete();
          pix = 0;
        end else if (shift_en) begin
          e.r = pix / W;
          e.c = pix % W;
          exp_wv = (e.r >= 2) && (e.c >= 2);
          if (exp_wv) begin
            e.r = e.r - 2;
            e.c = e.c - 2;
            q.push_back(e);
          end
          if (pix == 0) first_shift_cyc = cyc;
          last_shift_cyc = cyc;
          pix++;
        end else if (exp_wv && w_ready) begin
          exp_wv = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_pix(input int n, input string nm);
    int t = 0;
    while (pix < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, (pix >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_frames(input int n, input string nm);
    int t = 0;
    while (frame_count < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    #3;
    chk(nm, frame_count, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    int t;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    s_valid = 1'b0;
    w_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst s_ready", s_ready, 0);
    chk("rst shift_en", shift_en, 0);
    chk("rst window_valid", window_valid, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst busy", busy, 0);
    chk("rst win_row", win_row, 0);
    chk("rst win_col", win_col, 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // start and abort together in IDLE: stay idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #2;
    chk("start_abort busy", busy, 0);

    // Full-rate frame (also covers row-edge suppression via the window model)
    clear_model();
    fc = frame_count;
    s_valid = 1'b1;
    w_ready = 1'b1;
    pulse_start();
    wait_frames(fc + 1, "t1 frame_done");
    chk("t1 windows", win_count, 24);
    chk("t1 pixels", pix, 48);
    chk("t1 consecutive", last_shift_cyc - first_shift_cyc, 47);
    chk("t1 queue empty", q.size(), 0);
    chk("t1 idle busy", busy, 0);

    // Backpressure on window (1,3)
    clear_model();
    fc = frame_count;
    pulse_start();
    t = 0;
    while (!(window_valid && win_row == 1 && win_col == 3) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t3 found (1,3)", (t < 100) ? 1 : 0, 1);
    w_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t3 s_ready", s_ready, 0);
      chk("t3 shift_en", shift_en, 0);
      chk("t3 held valid", window_valid, 1);
      chk("t3 held row", win_row, 1);
      chk("t3 held col", win_col, 3);
      @(negedge clk);
    end
    w_ready = 1'b1;
    wait_frames(fc + 1, "t3 frame_done");
    chk("t3 windows", win_count, 24);

    // Random input bubbles
    clear_model();
    fc = frame_count;
    s_valid = 1'b0;
    pulse_start();
    t = 0;
    while (frame_count < fc + 1 && t < 1500) begin
      @(negedge clk);
      s_valid = 1'($urandom_range(0, 1));
      t++;
    end
    s_valid = 1'b0;
    #3;
    chk("t4 frame_done", frame_count, fc + 1);
    chk("t4 windows", win_count, 24);
    chk("t4 pixels", pix, 48);

    // Abort mid-RUN at pixel 20
    clear_model();
    fc = frame_count;
    s_valid = 1'b1;
    pulse_start();
    wait_pix(20, "t5 reach pixel 20");
    abort = 1'b1;
    s_valid = 1'b0;
    w_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    #2;
    chk("t5 window_valid", window_valid, 0);
    chk("t5 busy", busy, 0);
    chk("t5 frame_done", frame_done, 0);
    chk("t5 s_ready", s_ready, 0);
    repeat (4) @(negedge clk);
    chk("t5 no frame_done", frame_count, fc);
    clear_model();
    s_valid = 1'b1;
    w_ready = 1'b1;
    pulse_start();
    wait_frames(fc + 1, "t5 restart frame_done");
    chk("t5 restart windows", win_count, 24);

    // start during RUN ignored; async reset during DRAIN with a held window
    clear_model();
    fc = frame_count;
    pulse_start();
    wait_pix(10, "t6 reach pixel 10");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_pix(48, "t6 reach last pixel");
    w_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("t6 drain busy", busy, 1);
    chk("t6 drain valid", window_valid, 1);
    chk("t6 drain row", win_row, 3);
    chk("t6 drain col", win_col, 5);
    chk("t6 windows before reset", win_count, 23);
    #1;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6 rst s_ready", s_ready, 0);
    chk("t6 rst shift_en", shift_en, 0);
    chk("t6 rst window_valid", window_valid, 0);
    chk("t6 rst frame_done", frame_done, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst win_row", win_row, 0);
    chk("t6 rst win_col", win_col, 0);
    chk("t6 no frame_done", frame_count, fc);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv3x3_window_ctrl.md
Name: conv3x3_window_ctrl

Overview:
- Sequencer for the 3x3 stride-1 window generator (shift-register plus two line buffers).
- Accepts a raster pixel stream under valid/ready and drives the generator's shift enable.
- Tracks row and column, and asserts window_valid only for windows lying fully inside the image; windows that wrap a row edge are suppressed.
- Applies downstream backpressure by freezing the generator, and reports frame start and frame completion to the layer scheduler.

Parameters:
- IMG_WIDHT, 220, pixels per row; legal range ≥ 4.
- IMG_HEIGHT, 220, rows per frame; legal range ≥ 3.
- CNT_W, 16, width of the row, column and window-count registers; must hold max(IMG_WIDHT, IMG_HEIGHT).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  controller can accept a pixel.
- shift_en  out  1  drives the generator's Valid_in; equals s_valid & s_ready.
- w_ready  in  1  convolution engine accepts the current window.
- window_valid  out  1  generator outputs hold a complete in-image window.
- win_row  out  CNT_W  top-left row of the presented window.
- win_col  out  CNT_W  top-left column of the presented window.
- frame_done  out  1  one-cycle pulse after the last window is accepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; row = col = 0.
  - s_ready, shift_en, window_valid, frame_done and busy are all 0.
  - win_row = win_col = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: s_ready = 0. start → RUN, clearing row and col.
  - RUN: s_ready = ~window_valid | w_ready. Each shift advances col. When col = IMG_WIDHT-1, col wraps to 0 and row increments. A shift at (IMG_HEIGHT-1, IMG_WIDHT-1) → DRAIN.
  - DRAIN: s_ready = 0. Stays until window_valid is 0, or window_valid & w_ready occurs in this cycle; then → DONE.
  - DONE: frame_done = 1 for exactly one cycle → IDLE.
- Window qualification:
  - On a shift of pixel (row r, col c), window_valid is set at the next edge iff r ≥ 2 and c ≥ 2.
  - On that edge, win_row = r-2 and win_col = c-2 are registered.
  - This aligns with the generator's one-cycle DFF latency: outputs 1..9 present rows r-2..r, cols c-2..c.
- Window handshake:
  - window_valid & w_ready in a cycle with no shift → window_valid clears at the next edge.
  - A window is accepted and a new shift qualifies in the same cycle → the qualify result wins (valid stays 1 or clears according to the new pixel).
  - window_valid & ~w_ready → s_ready = 0, so the generator is frozen and window contents and coordinates stay stable.
  - window_valid never falls without w_ready, except on abort or reset.
- Count: exactly (IMG_WIDHT-2)*(IMG_HEIGHT-2) windows per frame.
  - No window for col 0 or 1 of any row, and none for rows 0 or 1.
- Simultaneous events:
  - abort overrides everything: → IDLE, window_valid = 0, counters cleared, no frame_done.
  - start outside IDLE is ignored.
  - start and abort together in IDLE → stay in IDLE.
- Line-buffer stale data from a prior frame is never exposed: the first qualified window requires two full new rows. No generator flush is needed.
- busy = (state != IDLE).
- frame_done and window_valid are never both 1.

Test Plan:
1. IMG_WIDHT=8, IMG_HEIGHT=6, s_valid and w_ready held high, start pulse.
   - 48 shifts in 48 consecutive cycles.
   - window_valid asserted exactly 24 times.
   - First window at win_row=0, win_col=0, one cycle after pixel 18 (row 2, col 2).
   - frame_done pulses 2 cycles after the last shift.
2. Row-edge suppression, same config:
   - After the shift of (3,0) and of (3,1), window_valid = 0.
   - After the shift of (3,2), window_valid = 1 with win_row=1, win_col=0.
3. Backpressure:
   - Hold w_ready=0 for 5 cycles while window (1,3) is presented.
   - s_ready and shift_en stay 0; Data_Out1..9, win_row and win_col are unchanged.
   - Next window appears 1 cycle after the shift that follows w_ready going 1.
4. Bubbles: s_valid random at 50% → still 24 windows, same coordinate order, one frame_done.
5. Abort mid-RUN at pixel 20:
   - Next cycle: IDLE, window_valid=0, busy=0, no frame_done.
   - A new start then yields a full 24-window frame.
6. Async reset asserted mid-DRAIN with window_valid=1 and w_ready=0:
   - All outputs 0 immediately, without waiting for a clock edge.
   - start during RUN is ignored: the frame is unaffected.
